// File: rtl/decode_dispatch_queue_if.sv
// rtl/decode_dispatch_queue_if.sv - fetch-side and issue-side handshake bundle for the dispatch queue
interface decode_dispatch_queue_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic [9:0]      unit_ready;
    logic [9:0]      issue_valid;
    logic [31:0]     issue_instr;
    logic [PC_W-1:0] issue_pc;

    modport master (
        output in_valid, in_instr, in_pc, unit_ready,
        input  in_ready, issue_valid, issue_instr, issue_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, unit_ready,
        output in_ready, issue_valid, issue_instr, issue_pc
    );
endinterface

// File: rtl/decode_dispatch_queue.sv
// rtl/decode_dispatch_queue.sv - in-order instruction queue that decodes the head into a dispatch unit class
module decode_dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    decode_dispatch_queue_if.slave     q,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           stall_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [31:0] head_instr;
    logic [3:0]  head_class;
    logic        not_empty;
    logic        enq;
    logic        deq;
    logic        head_blocked;

    // OP-FP: divide/sqrt go to the long FPU; moves to/from integer regs and illegal forms retire as class 0
    function automatic logic [3:0] fp_class(input logic [31:0] w);
        logic [4:0] f5;
        logic [1:0] fmt;
        logic [4:0] rs2;
        logic [2:0] f3;
        logic       rm_ok;
        logic [3:0] c;
        f5    = w[31:27];
        fmt   = w[26:25];
        rs2   = w[24:20];
        f3    = w[14:12];
        rm_ok = (f3 != 3'b101) && (f3 != 3'b110);
        c     = 4'd0;
        if (f5 == 5'b00011 || f5 == 5'b01011) begin
            c = 4'd7;
        end else if (fmt == 2'b00) begin
            case (f5)
                5'b00000, 5'b00001, 5'b00010: if (rm_ok) c = 4'd6;
                5'b00100:                     if (f3 <= 3'b010) c = 4'd6;
                5'b00101:                     if (f3 <= 3'b001) c = 4'd6;
                5'b10100:                     if (f3 <= 3'b010) c = 4'd6;
                5'b11000, 5'b11010:           if (rs2[4:1] == 4'd0 && rm_ok) c = 4'd6;
                5'b11100:                     if (f3 == 3'b001 && rs2 == 5'd0) c = 4'd6;
                default:                      c = 4'd0;
            endcase
        end
        return c;
    endfunction

    function automatic logic [3:0] decode_class(input logic [31:0] w);
        logic [3:0] c;
        case (w[6:0])
            7'b0000011, 7'b0000111:             c = 4'd4;
            7'b0100011, 7'b0100111:             c = 4'd5;
            7'b0010011, 7'b0010111:             c = 4'd1;
            7'b1100011, 7'b1100111, 7'b1101111: c = 4'd3;
            7'b0110011:                         c = (w[31:25] == 7'b0000001) ? 4'd2 : 4'd1;
            7'b1000011, 7'b1000111,
            7'b1001011, 7'b1001111:             c = 4'd7;
            7'b1010011:                         c = fp_class(w);
            7'b0010100, 7'b1010100:             c = 4'd8;
            7'b0010001:                         c = 4'd9;
            default:                            c = 4'd0;
        endcase
        return c;
    endfunction

    always_comb begin
        head_instr   = instr_mem[rd_ptr];
        head_class   = decode_class(head_instr);
        not_empty    = (count != '0);
        // class 0 never waits on a unit: it is dropped as soon as it reaches the head
        deq          = not_empty && ((head_class == 4'd0) || q.unit_ready[head_class]);
        head_blocked = not_empty && (head_class != 4'd0) && !q.unit_ready[head_class];
        enq          = q.in_valid && (count != FULL);
    end

    assign q.in_ready    = (count != FULL);
    assign q.issue_valid = (not_empty && head_class != 4'd0) ? (10'b1 << head_class) : 10'b0;
    assign q.issue_instr = head_instr;
    assign q.issue_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            instr_mem[wr_ptr] <= q.in_instr;
            pc_mem[wr_ptr]    <= q.in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // counts across flushes; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (head_blocked && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb/tb_decode_dispatch_queue.sv - directed self-checking bench for decode_dispatch_queue
module tb_decode_dispatch_queue;
    localparam logic [31:0] ADD  = 32'h00B50533;
    localparam logic [31:0] MUL  = 32'h02B50533;
    localparam logic [31:0] LUI  = 32'h123450B7;
    localparam logic [31:0] FDIV = 32'h183100D3;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  count;
    logic [15:0] stall_cycles;
    int          n_checks;
    int          n_fail;

    decode_dispatch_queue_if #(.PC_W(32)) qi ();

    decode_dispatch_queue #(.DEPTH(4), .PC_W(32), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .q            (qi.slave),
        .count        (count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  onehot;
    } dec_vec_t;

    dec_vec_t dec_tab [7];
    logic [31:0] pcq [$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        qi.in_valid   = 1'b0;
        qi.in_instr   = '0;
        qi.in_pc      = '0;
        qi.unit_ready = '0;

        dec_tab[0] = '{32'h00052083, 10'h010};
        dec_tab[1] = '{32'h00152023, 10'h020};
        dec_tab[2] = '{32'h003100D3, 10'h040};
        dec_tab[3] = '{32'hF00080D3, 10'h000};
        dec_tab[4] = '{32'h00000014, 10'h100};
        dec_tab[5] = '{32'h00000011, 10'h200};
        dec_tab[6] = '{32'h00000063, 10'h008};

        #1;
        check("rst_count", count, 0);
        check("rst_in_ready", qi.in_ready, 1);
        check("rst_issue_valid", qi.issue_valid, 0);
        check("rst_stall", stall_cycles, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // single add, all units ready
        qi.unit_ready = 10'h3FF;
        qi.in_valid = 1'b1; qi.in_instr = ADD; qi.in_pc = 32'h100;
        tick();
        qi.in_valid = 1'b0;
        check("add_issue_valid", qi.issue_valid, 10'h002);
        check("add_count", count, 1);
        check("add_pc", qi.issue_pc, 32'h100);
        check("add_instr", qi.issue_instr, ADD);
        tick();
        check("add_drained", count, 0);

        // mul blocked on long ALU for three cycles
        qi.unit_ready = 10'h3FB;
        qi.in_valid = 1'b1; qi.in_instr = MUL; qi.in_pc = 32'h104;
        tick();
        qi.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mul_hold", qi.issue_valid, 10'h004);
            tick();
        end
        qi.unit_ready = 10'h3FF;
        check("mul_hold_last", qi.issue_valid, 10'h004);
        check("mul_stall", stall_cycles, 3);
        tick();
        check("mul_drained", count, 0);
        check("mul_stall_after", stall_cycles, 3);

        // fill to full, then no enqueue in the first dequeue cycle
        qi.unit_ready = 10'h000;
        qi.in_instr = ADD;
        for (int i = 0; i < 4; i++) begin
            qi.in_valid = 1'b1; qi.in_pc = 32'h200 + 32'(4 * i);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", qi.in_ready, 0);
        check("full_stall", stall_cycles, 6);
        qi.in_pc = 32'h210;
        qi.unit_ready = 10'h3FF;
        tick();
        qi.in_valid = 1'b0;
        check("full_deq_count", count, 3);
        for (int i = 1; i < 4; i++) begin
            check("full_order_pc", qi.issue_pc, 32'h200 + 32'(4 * i));
            tick();
        end
        check("full_drained", count, 0);

        // class-0 head retires without issue, then fdiv.s goes to long FPU
        qi.in_valid = 1'b1; qi.in_instr = LUI; qi.in_pc = 32'h400;
        tick();
        qi.in_instr = FDIV; qi.in_pc = 32'h404;
        check("lui_issue_valid", qi.issue_valid, 0);
        check("lui_count", count, 1);
        tick();
        qi.in_valid = 1'b0;
        check("fdiv_issue_valid", qi.issue_valid, 10'h080);
        check("fdiv_pc", qi.issue_pc, 32'h404);
        check("fdiv_count", count, 1);
        tick();
        check("fdiv_drained", count, 0);

        foreach (dec_tab[k]) begin
            qi.in_valid = 1'b1; qi.in_instr = dec_tab[k].instr; qi.in_pc = 32'h500;
            tick();
            qi.in_valid = 1'b0;
            check("decode_class", qi.issue_valid, 64'(dec_tab[k].onehot));
            tick();
            check("decode_drained", count, 0);
        end

        // flush with a concurrent enqueue while three entries wait
        qi.unit_ready = 10'h000;
        qi.in_instr = ADD;
        for (int i = 0; i < 3; i++) begin
            qi.in_valid = 1'b1; qi.in_pc = 32'h600 + 32'(4 * i);
            tick();
        end
        check("pre_flush_count", count, 3);
        check("pre_flush_stall", stall_cycles, 8);
        qi.unit_ready = 10'h3FF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        qi.in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_in_ready", qi.in_ready, 1);
        check("flush_issue_valid", qi.issue_valid, 0);
        check("flush_stall", stall_cycles, 8);

        // ten entries through the ring with intermittent back-pressure
        begin
            int sent = 0;
            int cyc = 0;
            int exp_stall = 8;
            logic ready;
            logic enq;
            logic deq;
            logic [31:0] pc_now;
            pcq.delete();
            while ((sent < 10 || pcq.size() != 0) && cyc < 60) begin
                ready = (cyc % 3) != 0;
                pc_now = 32'h300 + 32'(4 * sent);
                qi.in_valid = (sent < 10);
                qi.in_pc = pc_now;
                qi.in_instr = ADD;
                qi.unit_ready = ready ? 10'h3FF : 10'h000;
                check("wrap_count", count, 64'(pcq.size()));
                check("wrap_in_ready", qi.in_ready, (pcq.size() != 4) ? 1 : 0);
                if (pcq.size() != 0) check("wrap_pc", qi.issue_pc, pcq[0]);
                enq = qi.in_valid && (pcq.size() != 4);
                deq = (pcq.size() != 0) && ready;
                if (pcq.size() != 0 && !ready) exp_stall++;
                tick();
                if (deq) void'(pcq.pop_front());
                if (enq) begin
                    pcq.push_back(pc_now);
                    sent++;
                end
                cyc++;
            end
            qi.in_valid = 1'b0;
            check("wrap_finished", (cyc < 60) ? 1 : 0, 1);
            check("wrap_stall", stall_cycles, 64'(exp_stall));
        end

        // asynchronous reset discards entries at once
        qi.unit_ready = 10'h000;
        qi.in_valid = 1'b1; qi.in_pc = 32'h700;
        tick();
        tick();
        qi.in_valid = 1'b0;
        check("pre_reset_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_stall", stall_cycles, 0);
        check("async_rst_in_ready", qi.in_ready, 1);
        check("async_rst_issue_valid", qi.issue_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_dispatch_queue.md
DECODE_DISPATCH_QUEUE -- requirements
Module: decode_dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 Parameter PC_W, default 32, width of the stored PC.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  fetch offers an instruction.
REQ-007 in_ready  output  1  queue accepts an instruction this cycle.
REQ-008 in_instr  input  32  RV32IF(+M, +custom I/O) instruction word.
REQ-009 in_pc  input  PC_W  PC of in_instr.
REQ-010 flush  input  1  discard all queued instructions.
REQ-011 unit_ready  input  10  per-dispatch-unit ready; index = unit class.
REQ-012 issue_valid  output  10  one-hot; head instruction offered to the indexed unit.
REQ-013 issue_instr  output  32  head instruction word.
REQ-014 issue_pc  output  PC_W  head PC.
REQ-015 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 stall_cycles  output  CNT_W  saturating count of blocked-head cycles.

Function
REQ-017 Unit classes: 0 none, 1 short ALU, 2 long ALU, 3 branch, 4 load, 5 store, 6 short FPU, 7 long FPU, 8 in, 9 out.
REQ-018 Class decode: opcodes 0000011/0000111 -> 4; 0100011/0100111 -> 5; 0010011, 0010111 -> 1; 1100011, 1100111, 1101111 -> 3.
REQ-019 Opcode 0110011 -> 2 when funct7 = 0000001 (RV32M), otherwise -> 1.
REQ-020 Opcodes 1000011/1000111/1001011/1001111 -> 7; opcode 1010011 -> 7 for funct7[6:2] 00011 or 01011.
REQ-021 Opcode 1010011 -> 0 for funct7[6:2] 11110, for 11100 with funct3 000, and for any encoding outside the RVF set; -> 6 for every other legal encoding.
REQ-022 Opcodes 0010100/1010100 -> 8; 0010001 -> 9; 0110111, 1110011 and all other opcodes -> 0.
REQ-023 Class is decoded combinationally from the head entry; it is not stored.
REQ-024 Queue is an in-order circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-025 in_ready = (count != DEPTH); an enqueue occurs when in_valid && in_ready.
REQ-026 When full, no enqueue occurs even if a dequeue happens in the same cycle.
REQ-027 An entry enqueued at edge t is visible at the head from cycle t+1 (one-cycle latency, no bypass).
REQ-028 issue_valid[c] = 1 iff count != 0, head class = c, and c != 0.
REQ-029 Class 1-9 dequeue when issue_valid[c] && unit_ready[c].
REQ-030 A class-0 head dequeues unconditionally in the cycle it is at the head, with issue_valid all zero.
REQ-031 At most one dequeue per cycle; simultaneous enqueue and dequeue leave count unchanged.
REQ-032 issue_instr and issue_pc show the head entry whenever count != 0 and are don't-care when empty.
REQ-033 flush: next cycle count = 0 and pointers = 0; flush beats both enqueue and dequeue in the same cycle.
REQ-034 stall_cycles increments when count != 0, the head class is not 0, and unit_ready[head class] = 0.
REQ-035 stall_cycles saturates at all-ones, is unaffected by flush, and is cleared only by reset.

Reset
REQ-036 While rst_n = 0: count = 0, pointers = 0, stall_cycles = 0, issue_valid = 0, in_ready = 1.
REQ-037 Queue entry storage is not reset.
REQ-038 Reset asserted mid-operation discards all entries immediately (asynchronous).

Verification
REQ-039 Enqueue add (0x00B50533) with unit_ready = all ones -> issue_valid = 0x002 one cycle later, dequeued that cycle, count back to 0.
REQ-040 Enqueue mul (0x02B50533) with unit_ready[2] = 0 for 3 cycles, then 1 -> issue_valid = 0x004 held 4 cycles, stall_cycles = 3.
REQ-041 Fill 4 entries with unit_ready = 0 -> in_ready = 0, count = 4; then raise ready while in_valid = 1 -> no enqueue in the dequeue cycle.
REQ-042 Enqueue lui, then fdiv.s -> lui retires with issue_valid = 0, next cycle issue_valid = 0x080.
REQ-043 Assert flush together with in_valid while count = 3 -> count = 0 next cycle, in_ready = 1, stall_cycles unchanged.
REQ-044 Over 10 enqueues, pointer wrap keeps program order of issue_pc.
